// File: rtl/gcd_multi_coprocessor.sv
// Multi-engine GCD coprocessor: NUM_UNITS subtract-and-swap engines
// sharing one request port and one tagged, out-of-order result FIFO.
module gcd_multi_coprocessor #(
    parameter int W          = 16,
    parameter int NUM_UNITS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             operands_val,
    input  logic [W-1:0]     operands_bits_A,
    input  logic [W-1:0]     operands_bits_B,
    input  logic [TAG_W-1:0] operands_tag,
    output logic             operands_rdy,
    output logic             result_val,
    output logic [W-1:0]     result_bits,
    output logic [TAG_W-1:0] result_tag,
    input  logic             result_rdy,
    output logic             busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = W + TAG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           st_q  [NUM_UNITS];
    state_t           st_d  [NUM_UNITS];
    logic [W-1:0]     a_q   [NUM_UNITS];
    logic [W-1:0]     a_d   [NUM_UNITS];
    logic [W-1:0]     b_q   [NUM_UNITS];
    logic [W-1:0]     b_d   [NUM_UNITS];
    logic [TAG_W-1:0] tag_q [NUM_UNITS];
    logic [TAG_W-1:0] tag_d [NUM_UNITS];

    logic [NUM_UNITS-1:0] idle;
    logic [NUM_UNITS-1:0] done;
    logic [NUM_UNITS-1:0] ld_gnt;
    logic [NUM_UNITS-1:0] wb_gnt;
    logic                 ld_found;
    logic                 wb_found;
    logic                 hs;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic [EW-1:0]        wb_entry;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] head;

    // Lowest-index priority for both loading and writeback
    always_comb begin
        idle     = '0;
        done     = '0;
        ld_gnt   = '0;
        wb_gnt   = '0;
        ld_found = 1'b0;
        wb_found = 1'b0;
        wb_entry = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idle[i] = (st_q[i] == IDLE);
            done[i] = (st_q[i] == DONE);
            if (idle[i] && !ld_found) begin
                ld_gnt[i] = 1'b1;
                ld_found  = 1'b1;
            end
            if (done[i] && !wb_found) begin
                wb_gnt[i] = 1'b1;
                wb_found  = 1'b1;
                wb_entry  = {a_q[i], tag_q[i]};
            end
        end
    end

    assign operands_rdy = reset && (|idle);
    assign hs           = operands_val && operands_rdy;
    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign push         = (|done) && !full;
    assign result_val   = (count != '0);
    assign pop          = result_val && result_rdy;
    assign head         = mem[rd_ptr];
    assign result_bits  = result_val ? head[TAG_W +: W] : '0;
    assign result_tag   = result_val ? head[TAG_W-1:0] : '0;
    assign busy         = (~&idle) || result_val;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            st_d[i]  = st_q[i];
            a_d[i]   = a_q[i];
            b_d[i]   = b_q[i];
            tag_d[i] = tag_q[i];
            unique case (st_q[i])
                IDLE: begin
                    if (hs && ld_gnt[i]) begin
                        a_d[i]   = operands_bits_A;
                        b_d[i]   = operands_bits_B;
                        tag_d[i] = operands_tag;
                        st_d[i]  = CALC;
                    end
                end
                CALC: begin
                    if (a_q[i] < b_q[i]) begin
                        a_d[i] = b_q[i];
                        b_d[i] = a_q[i];
                    end else if (b_q[i] != '0) begin
                        a_d[i] = a_q[i] - b_q[i];
                    end else begin
                        st_d[i] = DONE;
                    end
                end
                DONE: begin
                    if (push && wb_gnt[i]) begin
                        st_d[i] = IDLE;
                    end
                end
                default: st_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                st_q[i]  <= IDLE;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                st_q[i]  <= st_d[i];
                a_q[i]   <= a_d[i];
                b_q[i]   <= b_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wb_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_multi_coprocessor.sv
// Directed self-checking bench for gcd_multi_coprocessor
// (default parameters: W=16, NUM_UNITS=2, FIFO_DEPTH=4, TAG_W=4).
module tb_gcd_multi_coprocessor;

    logic        clk = 1'b0;
    logic        reset;
    logic        operands_val;
    logic [15:0] operands_bits_A;
    logic [15:0] operands_bits_B;
    logic [3:0]  operands_tag;
    logic        operands_rdy;
    logic        result_val;
    logic [15:0] result_bits;
    logic [3:0]  result_tag;
    logic        result_rdy;
    logic        busy;

    int npass  = 0;
    int ntotal = 0;

    gcd_multi_coprocessor dut (
        .clk             (clk),
        .reset           (reset),
        .operands_val    (operands_val),
        .operands_bits_A (operands_bits_A),
        .operands_bits_B (operands_bits_B),
        .operands_tag    (operands_tag),
        .operands_rdy    (operands_rdy),
        .result_val      (result_val),
        .result_bits     (result_bits),
        .result_tag      (result_tag),
        .result_rdy      (result_rdy),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t);
        bit ok;
        ok = 1'b0;
        operands_val    = 1'b1;
        operands_bits_A = a;
        operands_bits_B = b;
        operands_tag    = t;
        for (int i = 0; i < 1000; i++) begin
            if (operands_rdy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            ntotal++;
            $display("FAIL issue_timeout tag=%0d got rdy=0 want rdy=1", t);
        end
        operands_val = 1'b0;
    endtask

    task automatic wait_result(output logic [15:0] bits, output logic [3:0] t,
                               output int edges, output bit ok);
        ok    = 1'b0;
        edges = 0;
        bits  = '0;
        t     = '0;
        for (int i = 0; i < 2000; i++) begin
            if (result_val) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
        if (ok) begin
            bits       = result_bits;
            t          = result_tag;
            result_rdy = 1'b1;
            @(posedge clk); #1;
            result_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ntotal++;
        if (operands_rdy !== 1'b0)
            $display("FAIL rst_rdy got %b want 0", operands_rdy);
        else npass++;
        ntotal++;
        if (result_val !== 1'b0)
            $display("FAIL rst_val got %b want 0", result_val);
        else npass++;
        ntotal++;
        if (result_bits !== 16'd0)
            $display("FAIL rst_bits got %0d want 0", result_bits);
        else npass++;
        ntotal++;
        if (result_tag !== 4'd0)
            $display("FAIL rst_tag got %0d want 0", result_tag);
        else npass++;
        ntotal++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy got %b want 0", busy);
        else npass++;
        reset = 1'b1;
        #1;
        ntotal++;
        if (operands_rdy !== 1'b1)
            $display("FAIL rst_release_rdy got %b want 1", operands_rdy);
        else npass++;
    endtask

    task automatic test_single();
        logic [15:0] bits;
        logic [3:0]  t;
        int          e;
        bit          ok;
        issue(16'd27, 16'd15, 4'd3);
        wait_result(bits, t, e, ok);
        ntotal++;
        if (!ok || bits !== 16'd3)
            $display("FAIL single_bits got %0d ok=%0d want 3", bits, ok);
        else npass++;
        ntotal++;
        if (t !== 4'd3)
            $display("FAIL single_tag got %0d want 3", t);
        else npass++;
        ntotal++;
        if (result_val !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_drain got val=%b busy=%b want 0 0",
                     result_val, busy);
        else npass++;
    endtask

    task automatic test_latency();
        logic [15:0] bits;
        logic [3:0]  t;
        int          e;
        bit          ok;
        issue(16'd0, 16'd0, 4'd5);
        wait_result(bits, t, e, ok);
        ntotal++;
        if (!ok || bits !== 16'd0 || e != 2)
            $display("FAIL lat_0_0 got bits=%0d edges=%0d want bits=0 edges=2",
                     bits, e);
        else npass++;
        issue(16'd40, 16'd40, 4'd6);
        wait_result(bits, t, e, ok);
        ntotal++;
        if (!ok || bits !== 16'd40 || e != 4)
            $display("FAIL lat_40_40 got bits=%0d edges=%0d want bits=40 edges=4",
                     bits, e);
        else npass++;
    endtask

    task automatic test_out_of_order();
        logic [15:0] bits;
        logic [3:0]  t;
        int          e;
        bit          ok;
        issue(16'd6993, 16'd999, 4'd1);
        issue(16'd2, 16'd1, 4'd2);
        ntotal++;
        if (operands_rdy !== 1'b0)
            $display("FAIL ooo_rdy got %b want 0", operands_rdy);
        else npass++;
        wait_result(bits, t, e, ok);
        ntotal++;
        if (!ok || t !== 4'd2 || bits !== 16'd1)
            $display("FAIL ooo_first got tag=%0d bits=%0d want tag=2 bits=1",
                     t, bits);
        else npass++;
        wait_result(bits, t, e, ok);
        ntotal++;
        if (!ok || t !== 4'd1 || bits !== 16'd999)
            $display("FAIL ooo_second got tag=%0d bits=%0d want tag=1 bits=999",
                     t, bits);
        else npass++;
    endtask

    task automatic test_fifo_full();
        logic [15:0] bits;
        logic [15:0] hb;
        logic [3:0]  t;
        logic [3:0]  ht;
        logic [7:0]  mask;
        int          e;
        bit          ok;
        result_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            issue(16'd5, 16'd250, 4'(i));
        end
        repeat (80) @(posedge clk);
        #1;
        ntotal++;
        if (result_val !== 1'b1 || operands_rdy !== 1'b0 || busy !== 1'b1)
            $display("FAIL full_state got val=%b rdy=%b busy=%b want 1 0 1",
                     result_val, operands_rdy, busy);
        else npass++;
        hb = result_bits;
        ht = result_tag;
        repeat (3) @(posedge clk);
        #1;
        ntotal++;
        if (result_bits !== hb || result_tag !== ht)
            $display("FAIL full_stable got %0d/%0d want %0d/%0d",
                     result_bits, result_tag, hb, ht);
        else npass++;
        mask = '0;
        for (int i = 0; i < 6; i++) begin
            wait_result(bits, t, e, ok);
            ntotal++;
            if (!ok || bits !== 16'd5 || mask[t[2:0]] || t == 0 || t > 6)
                $display("FAIL full_pop%0d got bits=%0d tag=%0d want bits=5 new tag",
                         i, bits, t);
            else npass++;
            if (ok && t < 8) mask[t[2:0]] = 1'b1;
        end
        ntotal++;
        if (mask !== 8'b0111_1110)
            $display("FAIL full_tags got %b want 01111110", mask);
        else npass++;
        repeat (20) @(posedge clk);
        #1;
        ntotal++;
        if (result_val !== 1'b0 || busy !== 1'b0)
            $display("FAIL full_empty got val=%b busy=%b want 0 0",
                     result_val, busy);
        else npass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] bits;
        logic [3:0]  t;
        int          e;
        bit          ok;
        bit          stale;
        issue(16'd250, 16'd190, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        ntotal++;
        if (result_val !== 1'b0 || busy !== 1'b0 || operands_rdy !== 1'b0)
            $display("FAIL mid_rst got val=%b busy=%b rdy=%b want 0 0 0",
                     result_val, busy, operands_rdy);
        else npass++;
        @(posedge clk); #1;
        reset = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_val) stale = 1'b1;
        end
        ntotal++;
        if (stale !== 1'b0)
            $display("FAIL mid_stale got result_val=1 want 0");
        else npass++;
        issue(16'd96, 16'd4096, 4'd8);
        wait_result(bits, t, e, ok);
        ntotal++;
        if (!ok || bits !== 16'd32 || t !== 4'd8)
            $display("FAIL mid_after got bits=%0d tag=%0d want 32 8", bits, t);
        else npass++;
    endtask

    task automatic test_legacy();
        logic [15:0] va  [16];
        logic [15:0] vb  [16];
        logic [15:0] exp [16];
        logic [15:0] seen;
        int          got;
        int          cyc;
        va  = '{16'd250, 16'd103, 16'd27, 16'd0, 16'd0, 16'd9, 16'd40, 16'd6993,
                16'd96, 16'd1071, 16'd48, 16'd1, 16'd65535, 16'd12, 16'd100, 16'd17};
        vb  = '{16'd370, 16'd199, 16'd15, 16'd0, 16'd7, 16'd0, 16'd40, 16'd999,
                16'd4096, 16'd462, 16'd18, 16'd1, 16'd255, 16'd8, 16'd75, 16'd51};
        exp = '{16'd10, 16'd1, 16'd3, 16'd0, 16'd7, 16'd9, 16'd40, 16'd999,
                16'd32, 16'd21, 16'd6, 16'd1, 16'd255, 16'd4, 16'd25, 16'd17};
        seen = '0;
        got  = 0;
        cyc  = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    issue(va[i], vb[i], 4'(i));
                end
            end
            begin
                while (got < 16 && cyc < 20000) begin
                    @(negedge clk);
                    if (result_val && result_rdy) begin
                        ntotal++;
                        if (seen[result_tag] || result_bits !== exp[result_tag])
                            $display("FAIL legacy tag=%0d got %0d want %0d dup=%0d",
                                     result_tag, result_bits, exp[result_tag],
                                     seen[result_tag]);
                        else npass++;
                        seen[result_tag] = 1'b1;
                        got++;
                    end
                    @(posedge clk); #1;
                    result_rdy = 1'($urandom_range(0, 1));
                    cyc++;
                end
            end
        join
        result_rdy = 1'b0;
        ntotal++;
        if (got != 16 || seen !== 16'hFFFF)
            $display("FAIL legacy_all got count=%0d mask=%h want 16 ffff",
                     got, seen);
        else npass++;
    endtask

    initial begin
        reset           = 1'b0;
        operands_val    = 1'b0;
        operands_bits_A = '0;
        operands_bits_B = '0;
        operands_tag    = '0;
        result_rdy      = 1'b0;
        test_reset();
        test_single();
        test_latency();
        test_out_of_order();
        test_fifo_full();
        test_reset_mid();
        test_legacy();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
